// File: rtl/apb_pkg.sv
// Shared APB definitions for the requester and completer sides: bus FSM states,
// default bus widths and the command record.
package apb_pkg;

  localparam int unsigned ApbAddrWidth = 6;
  localparam int unsigned ApbDataWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                    write;
    logic [ApbAddrWidth-1:0] addr;
    logic [ApbDataWidth-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS wait-state watchdog: counts enabled cycles and flags the cycle on which the
// TimeoutCycles-th wait would complete.
module apb_timeout_counter #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] count_q, count_d;

  // The count would reach TimeoutCycles on this edge, so abort now.
  assign expired = enable && (count_q == CntWidth'(TimeoutCycles - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master_8bit.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfer out, one-cycle response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TimeoutCycles wait states.
module apb_master_8bit
  import apb_pkg::*;
#(
  parameter int unsigned AddrWidth     = ApbAddrWidth,
  parameter int unsigned DataWidth     = ApbDataWidth,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [DataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [AddrWidth-1:0] paddr,
  output logic [DataWidth-1:0] pwdata,
  input  logic [DataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  if (DataWidth != 8 || TimeoutCycles == 0) begin : g_bad_param
    $error("apb_master_8bit: DataWidth must be 8 and TimeoutCycles nonzero");
  end

  apb_state_e           state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [AddrWidth-1:0] paddr_q, paddr_d;
  logic [DataWidth-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  logic rsp_timeout_q, rsp_timeout_d;
  logic tmo_expired;

  apb_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == SETUP),
    .enable ((state_q == ACCESS) && !pready),
    .expired(tmo_expired)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Completion takes priority over a watchdog expiring on the same cycle.
        if (pready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (tmo_expired) begin
          state_d       = IDLE;
          cmd_ready_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_8bit.sv
// Directed bench for apb_master_8bit with a 64-entry byte completer model that has
// programmable wait states and error response.
module tb_apb_master_8bit;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [5:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr;

  int total = 0;
  int bad   = 0;

  apb_master_8bit #(
    .AddrWidth    (6),
    .DataWidth    (8),
    .TimeoutCycles(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  // Completer model; pslverr and prdata carry junk outside the completing cycle.
  logic [7:0] mem [64];
  int         wait_cnt = 0;
  int         cfg_waits = 0;
  logic       cfg_err = 1'b0;

  assign pready  = psel && penable && (wait_cnt == cfg_waits);
  assign prdata  = pready ? mem[paddr] : 8'hEE;
  assign pslverr = pready ? cfg_err : 1'b1;

  always @(posedge clk) begin
    if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
    if (pready && pwrite && !cfg_err) mem[paddr] <= pwdata;
  end

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  // Issues one command at a negedge and follows it to its response pulse.
  task automatic xfer(input int tag, input logic wr, input logic [5:0] a, input logic [7:0] d,
                      input int waits, input logic err, input logic [7:0] exp_rdata,
                      input logic exp_err, input logic exp_tmo, input int exp_lat);
    int   cyc;
    bit   stable;
    bit   done;
    logic p1, e1, e2;
    cfg_waits = waits;
    cfg_err   = err;
    for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready", tag, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cyc = 0; stable = 1'b1; done = 1'b0;
    p1 = 1'b0; e1 = 1'b1; e2 = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      // Garbage on the command fields must not reach the bus after the handshake.
      cmd_valid = 1'b0;
      cmd_write = ~wr;
      cmd_addr  = ~a;
      cmd_wdata = ~d;
      cyc++;
      if (cyc == 1) begin p1 = psel; e1 = penable; end
      if (cyc == 2) e2 = penable;
      if (rsp_valid) done = 1'b1;
      else if (paddr != a || pwrite != wr || (wr && pwdata != d)) stable = 1'b0;
    end
    chk("latency", tag, 32'(cyc), 32'(exp_lat));
    chk("psel_setup", tag, 32'(p1), 32'd1);
    chk("penable_setup", tag, 32'(e1), 32'd0);
    chk("penable_access", tag, 32'(e2), 32'd1);
    chk("bus_stable", tag, 32'(stable), 32'd1);
    chk("rsp_rdata", tag, 32'(rsp_rdata), 32'(exp_rdata));
    chk("rsp_err", tag, 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", tag, 32'(rsp_timeout), 32'(exp_tmo));
    chk("psel_done", tag, 32'(psel), 32'd0);
    chk("cmd_ready_done", tag, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("rsp_pulse", tag, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       err;
    logic [7:0] rdata;
    logic       rerr;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  logic [5:0] bb_addr [3];
  logic [7:0] bb_data [3];
  int         hs_cyc [$];
  int         rsp_cyc [$];
  int         setups;
  int         idx;
  bit         hs;
  bit         stray;

  initial begin
    vecs[0] = '{1'b1, 6'h03, 8'hA5, 0, 1'b0, 8'h00, 1'b0, 3};
    vecs[1] = '{1'b0, 6'h03, 8'h00, 0, 1'b0, 8'hA5, 1'b0, 3};
    vecs[2] = '{1'b1, 6'h3F, 8'h5C, 1, 1'b0, 8'h00, 1'b0, 4};
    vecs[3] = '{1'b0, 6'h3F, 8'h00, 4, 1'b0, 8'h5C, 1'b0, 7};
    vecs[4] = '{1'b1, 6'h10, 8'h77, 0, 1'b1, 8'h00, 1'b1, 3};
    vecs[5] = '{1'b0, 6'h10, 8'h00, 2, 1'b0, 8'h00, 1'b0, 5};
    vecs[6] = '{1'b0, 6'h03, 8'h00, 0, 1'b1, 8'hA5, 1'b1, 3};
    vecs[7] = '{1'b1, 6'h00, 8'hFF, 3, 1'b0, 8'h00, 1'b0, 6};
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 0, 32'(cmd_ready), 32'd1);
    chk("rst_psel", 0, 32'(psel), 32'd0);
    chk("rst_penable", 0, 32'(penable), 32'd0);
    chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    chk("rst_bus", 0, {17'd0, pwrite, paddr, pwdata}, 32'd0);
    chk("rst_rsp", 0, {22'd0, rsp_err, rsp_timeout, rsp_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      xfer(v, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].err,
           vecs[v].rdata, vecs[v].rerr, 1'b0, vecs[v].lat);
    end

    // Back-to-back: cmd_valid held high across three writes.
    bb_addr[0] = 6'h20; bb_addr[1] = 6'h21; bb_addr[2] = 6'h22;
    bb_data[0] = 8'h11; bb_data[1] = 8'h22; bb_data[2] = 8'h33;
    cfg_waits = 0; cfg_err = 1'b0;
    idx = 0; setups = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = bb_addr[0]; cmd_wdata = bb_data[0];
    for (int c = 0; c < 14; c++) begin
      hs = cmd_valid && cmd_ready;
      if (hs) hs_cyc.push_back(c);
      if (rsp_valid) rsp_cyc.push_back(c);
      if (psel && !penable) setups++;
      @(negedge clk);
      if (hs) begin
        idx++;
        if (idx < 3) begin
          cmd_addr = bb_addr[idx]; cmd_wdata = bb_data[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("b2b_handshakes", 0, 32'(hs_cyc.size()), 32'd3);
    chk("b2b_responses", 0, 32'(rsp_cyc.size()), 32'd3);
    chk("b2b_setups", 0, 32'(setups), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < hs_cyc.size()) chk("b2b_hs_cycle", i, 32'(hs_cyc[i]), 32'(3 * i));
      if (i < rsp_cyc.size()) chk("b2b_rsp_cycle", i, 32'(rsp_cyc[i]), 32'(3 * i + 3));
    end
    for (int i = 0; i < 3; i++) begin
      xfer(20 + i, 1'b0, bb_addr[i], 8'h00, 0, 1'b0, bb_data[i], 1'b0, 1'b0, 3);
    end

    // Reset pulsed in the middle of a waited ACCESS.
    cfg_waits = 10; cfg_err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h03;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    chk("pre_rst_penable", 0, 32'(penable), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_psel", 0, 32'(psel), 32'd0);
    chk("mid_rst_penable", 0, 32'(penable), 32'd0);
    chk("mid_rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 0, 32'(cmd_ready), 32'd1);
    stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || psel) stray = 1'b1;
    end
    chk("post_rst_quiet", 0, 32'(stray), 32'd0);
    xfer(30, 1'b0, 6'h03, 8'h00, 0, 1'b0, 8'hA5, 1'b0, 1'b0, 3);

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never ready: 16 ACCESS wait cycles, then abort.
    xfer(40, 1'b0, 6'h03, 8'h00, 1000, 1'b0, 8'h00, 1'b1, 1'b1, 18);
    xfer(41, 1'b0, 6'h03, 8'h00, 15, 1'b0, 8'hA5, 1'b0, 1'b0, 18);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
